// File: rtl/mdu_hilo_pkg.sv
// Shared MDU definitions: op encodings, default latencies, FSM state and op decode.
// Optional MDU_MADD_EN widens Op to 4 bits (Op[3]=unsigned) and enables MADD/MSUB.
package mdu_hilo_pkg;

`ifdef MDU_MADD_EN
  localparam int OP_W = 4;
`else
  localparam int OP_W = 3;
`endif

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic mul;
    logic div;
    logic mthi;
    logic mtlo;
    logic sgn;
`ifdef MDU_MADD_EN
    logic acc;
    logic sub;
`endif
  } dec_t;

  function automatic dec_t decode(input logic [OP_W-1:0] op);
    dec_t d;
    logic base;
    d = '0;
`ifdef MDU_MADD_EN
    // Op[3] only qualifies the accumulate ops; elsewhere it makes the op undefined
    base = !op[3];
    if (op[2:0] == OP_MADD || op[2:0] == OP_MSUB) begin
      d.acc = 1'b1;
      d.sub = (op[2:0] == OP_MSUB);
      d.sgn = !op[3];
    end
`else
    base = 1'b1;
`endif
    if (base) begin
      d.mul  = (op[2:0] == OP_MULT) || (op[2:0] == OP_MULTU);
      d.div  = (op[2:0] == OP_DIV)  || (op[2:0] == OP_DIVU);
      d.mthi = (op[2:0] == OP_MTHI);
      d.mtlo = (op[2:0] == OP_MTLO);
      if (op[2:0] == OP_MULT || op[2:0] == OP_DIV) d.sgn = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Combinational 32-bit quotient/remainder with MIPS divide-by-zero and overflow results.
module mdu_div (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sgn,
  output logic [31:0] q,
  output logic [31:0] r
);

  always_comb begin
    q = '1;
    r = a;
    if (b != '0) begin
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = '0;
      end else if (sgn) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO; result is computed at accept and held until completion.
// Optional MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulating into HI/LO at completion.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [OP_W-1:0] Op,
  input  logic [31:0]     RS,
  input  logic [31:0]     RT,
  output logic            Busy,
  output logic [31:0]     HI,
  output logic [31:0]     LO
);

  localparam logic [4:0] MUL_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

  dec_t        dec;
  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] pend;
  logic [63:0] prod;
  logic [63:0] wb;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        mul_go;

  assign dec = decode(Op);

  // Sign-extend for signed ops so one 64x64 multiply (low half kept) serves both flavours
  assign prod = {{32{dec.sgn & RS[31]}}, RS} * {{32{dec.sgn & RT[31]}}, RT};

  mdu_div u_div (
    .a   (RS),
    .b   (RT),
    .sgn (dec.sgn),
    .q   (quo),
    .r   (rem)
  );

`ifdef MDU_MADD_EN
  logic acc_en;
  logic acc_sub;
  assign mul_go = dec.mul | dec.acc;
  assign wb = !acc_en ? pend : acc_sub ? {HI, LO} - pend : {HI, LO} + pend;
`else
  assign mul_go = dec.mul;
  assign wb     = pend;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      Busy  <= 1'b0;
      cnt   <= '0;
      pend  <= '0;
      HI    <= '0;
      LO    <= '0;
`ifdef MDU_MADD_EN
      acc_en  <= 1'b0;
      acc_sub <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (Start) begin
          if (mul_go) begin
            pend  <= prod;
            cnt   <= MUL_LOAD;
            Busy  <= 1'b1;
            state <= RUN;
`ifdef MDU_MADD_EN
            acc_en  <= dec.acc;
            acc_sub <= dec.sub;
`endif
          end else if (dec.div) begin
            pend  <= {rem, quo};
            cnt   <= DIV_LOAD;
            Busy  <= 1'b1;
            state <= RUN;
`ifdef MDU_MADD_EN
            acc_en <= 1'b0;
`endif
          end else if (dec.mthi) begin
            HI <= RS;
          end else if (dec.mtlo) begin
            LO <= RS;
          end
        end
        RUN: begin
          // Start is deliberately not looked at here, including the final cycle
          if (cnt != '0) begin
            cnt <= cnt - 5'd1;
          end else begin
            {HI, LO} <= wb;
            Busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: fixed vector table, hand-built corner sequences, random ops vs reference model.
module tb_mdu_hilo;
  import mdu_hilo_pkg::*;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            Start;
  logic [OP_W-1:0] Op;
  logic [31:0]     RS;
  logic [31:0]     RT;
  logic            Busy;
  logic [31:0]     HI;
  logic [31:0]     LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_hilo dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Op    (Op),
    .RS    (RS),
    .RT    (RT),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int lat(input int op);
    if (op == 0 || op == 1) return 5;
    if (op == 2 || op == 3) return 10;
    return 0;
  endfunction

  // Architectural reference: plain 64-bit arithmetic on the operands
  task automatic model(input int op, input logic [31:0] rs, input logic [31:0] rt,
                       inout logic [31:0] hi, inout logic [31:0] lo);
    longint a, b, q, r;
    longint unsigned pu;
    case (op)
      0: begin
        a = longint'($signed(rs)) * longint'($signed(rt));
        hi = a[63:32]; lo = a[31:0];
      end
      1: begin
        pu = longint'(rs) * longint'(rt);
        hi = pu[63:32]; lo = pu[31:0];
      end
      2, 3: begin
        if (rt == 0) begin
          lo = 32'hFFFF_FFFF; hi = rs;
        end else if (op == 2 && rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000; hi = 0;
        end else if (op == 2) begin
          a = longint'($signed(rs)); b = longint'($signed(rt));
          q = a / b; r = a - q * b;
          lo = q[31:0]; hi = r[31:0];
        end else begin
          lo = rs / rt; hi = rs - lo * rt;
        end
      end
      4: hi = rs;
      5: lo = rs;
      default: ;
    endcase
  endtask

  task automatic run_op(input int op, input logic [31:0] rs, input logic [31:0] rt, input string name);
    logic [31:0] oh, ol;
    int n;
    oh = m_hi; ol = m_lo; n = lat(op);
    model(op, rs, rt, m_hi, m_lo);
    @(negedge Clk);
    Op = OP_W'(op); RS = rs; RT = rt; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0; RS = $urandom; RT = $urandom;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      chk({name, " busy"}, 32'(Busy), 32'd1);
      chk({name, " hi held"}, HI, oh);
      chk({name, " lo held"}, LO, ol);
      @(posedge Clk);
    end
    @(negedge Clk);
    chk({name, " busy done"}, 32'(Busy), 32'd0);
    chk({name, " hi"}, HI, m_hi);
    chk({name, " lo"}, LO, m_lo);
  endtask

  typedef struct {
    int          op;
    logic [31:0] rs, rt, ehi, elo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] rs, rt, dhi, dlo;
    int op;

    vecs[0] = '{0, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3, 32'd100,       32'd0,          32'd100,       32'hFFFF_FFFF};
    vecs[4] = '{2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};
    vecs[6] = '{3, 32'hFFFF_FFFF, 32'd10,         32'd5,         32'h1999_9999};
    vecs[7] = '{2, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF};

    Reset = 1'b1; Start = 1'b0; Op = '0; RS = '0; RT = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset busy", 32'(Busy), 32'd0);
    chk("reset hi", HI, 32'd0);
    chk("reset lo", LO, 32'd0);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table hi", i), HI, vecs[i].ehi);
      chk($sformatf("vec%0d table lo", i), LO, vecs[i].elo);
    end

    // Moves take effect on the sampling edge without raising Busy
    run_op(4, 32'h1234_5678, 32'd0, "mthi");
    chk("mthi const", HI, 32'h1234_5678);
    run_op(5, 32'hCAFE_F00D, 32'd0, "mtlo");
    run_op(6, 32'h1111_1111, 32'd3, "undef6");
    run_op(7, 32'h2222_2222, 32'd3, "undef7");

    // DIV with stray MULT starts at cycle 2 and on the falling-Busy cycle
    model(2, 32'd1000, 32'd7, m_hi, m_lo);
    dhi = m_hi; dlo = m_lo;
    @(negedge Clk);
    Op = OP_W'(2); RS = 32'd1000; RT = 32'd7; Start = 1'b1;
    for (int e = 0; e < 10; e++) begin
      @(negedge Clk);
      chk($sformatf("ign busy e%0d", e), 32'(Busy), 32'd1);
      if (e == 1 || e == 9) begin
        Start = 1'b1; Op = OP_W'(0); RS = 32'h0000_0003; RT = 32'h0000_0005;
      end else begin
        Start = 1'b0;
      end
    end
    @(negedge Clk);
    Start = 1'b0;
    chk("ign busy fall", 32'(Busy), 32'd0);
    chk("ign div hi", HI, 32'd6);
    chk("ign div lo", LO, 32'd142);
    repeat (8) @(negedge Clk);
    chk("ign busy later", 32'(Busy), 32'd0);
    chk("ign hi later", HI, dhi);
    chk("ign lo later", LO, dlo);

    // Reset two cycles into a MULT: clears everything, no later write
    @(negedge Clk);
    Op = OP_W'(0); RS = 32'd9; RT = 32'd9; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst mid busy", 32'(Busy), 32'd0);
    chk("rst mid hi", HI, 32'd0);
    chk("rst mid lo", LO, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (8) @(negedge Clk);
    chk("rst after busy", 32'(Busy), 32'd0);
    chk("rst after hi", HI, 32'd0);
    chk("rst after lo", LO, 32'd0);

    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 7));
      rs = $urandom;
      rt = $urandom;
      case ($urandom_range(0, 5))
        0: rt = 32'd0;
        1: begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
        2: rt = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(op, rs, rt, $sformatf("rnd%0d op%0d", k, op));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
